// File: rtl/round_pkg.sv
// Shared types, codes and counter widths for the match/round sequencer.
package round_pkg;

   localparam int unsigned CNT_W   = 8;   // intro / KO-hold tick counter
   localparam int unsigned SUB_W   = 5;   // ticks within one displayed second
   localparam int unsigned TIMER_W = 7;   // round clock, 0..99 s
   localparam int unsigned ROUND_W = 3;
   localparam int unsigned WINS_W  = 2;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_INTRO      = 3'd1,
      ST_FIGHT      = 3'd2,
      ST_KO         = 3'd3,
      ST_MATCH_OVER = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      WIN_NONE = 2'b00,
      WIN_P1   = 2'b01,
      WIN_P2   = 2'b10,
      WIN_DRAW = 2'b11
   } winner_e;

   // Intro digit: ceil(remaining / tps) clamped to 1..3, without a divider.
   function automatic logic [1:0] intro_digit(input int unsigned remaining,
                                              input int unsigned tps);
      if (remaining > 2 * tps) return 2'd3;
      else if (remaining > tps) return 2'd2;
      else return 2'd1;
   endfunction

endpackage

// File: rtl/round_clock.sv
// Round clock: per-second tick sub-counter and the seconds down-counter.
module round_clock
   import round_pkg::*;
#(
   parameter int unsigned TICKS_PER_SEC = 20,
   parameter int unsigned ROUND_TIME_S  = 60
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic               enable_i,
   output logic [TIMER_W-1:0] timer_sec_o,
   output logic               time_up_o
);

   localparam logic [SUB_W-1:0]   SUB_LAST   = SUB_W'(TICKS_PER_SEC - 1);
   localparam logic [TIMER_W-1:0] TIME_START = TIMER_W'(ROUND_TIME_S);

   logic [SUB_W-1:0]   sub_q, sub_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic               time_up_q, time_up_d;

   // time_up pulses on the same edge that timer_sec lands on 0.
   always_comb begin
      sub_d     = sub_q;
      timer_d   = timer_q;
      time_up_d = 1'b0;
      if (load_i) begin
         sub_d   = '0;
         timer_d = TIME_START;
      end else if (enable_i) begin
         if (sub_q == SUB_LAST) begin
            sub_d = '0;
            if (timer_q != '0) begin
               timer_d   = timer_q - TIMER_W'(1);
               time_up_d = (timer_q == TIMER_W'(1));
            end
         end else begin
            sub_d = sub_q + SUB_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sub_q     <= '0;
         timer_q   <= TIME_START;
         time_up_q <= 1'b0;
      end else begin
         sub_q     <= sub_d;
         timer_q   <= timer_d;
         time_up_q <= time_up_d;
      end
   end

   assign timer_sec_o = timer_q;
   assign time_up_o   = time_up_q;

endmodule

// File: rtl/round_manager.sv
// Match/round sequencer: intro countdown, timed fight, KO/time-up decision,
// best-of-N tally, freeze gate and round-reset request.
module round_manager
   import round_pkg::*;
#(
   parameter int unsigned TICKS_PER_SEC = 20,
   parameter int unsigned ROUND_TIME_S  = 60,
   parameter int unsigned INTRO_TICKS   = 60,
   parameter int unsigned KO_HOLD_TICKS = 40,
   parameter int unsigned ROUNDS_TO_WIN = 2,
   parameter int unsigned MAX_ROUNDS    = 5,
   parameter int unsigned HEALTH_W      = 9
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                tick,
   input  logic [HEALTH_W-1:0] health_1,
   input  logic [HEALTH_W-1:0] health_2,
   input  logic                start_btn,
   output logic                freeze,
   output logic                round_reset,
   output logic [2:0]          state,
   output logic [2:0]          round_no,
   output logic [1:0]          wins_1,
   output logic [1:0]          wins_2,
   output logic [6:0]          timer_sec,
   output logic [1:0]          countdown,
   output logic [1:0]          round_winner,
   output logic [1:0]          match_winner
);

   localparam logic [CNT_W-1:0]   INTRO_LAST  = CNT_W'(INTRO_TICKS - 1);
   localparam logic [CNT_W-1:0]   KO_LAST     = CNT_W'(KO_HOLD_TICKS - 1);
   localparam logic [WINS_W-1:0]  WINS_MAX    = WINS_W'(ROUNDS_TO_WIN);
   localparam logic [ROUND_W-1:0] ROUND_LAST  = ROUND_W'(MAX_ROUNDS);
   localparam logic [1:0]         DIGIT_START = intro_digit(INTRO_TICKS, TICKS_PER_SEC);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ROUND_W-1:0]  round_no_q, round_no_d;
   logic [WINS_W-1:0]   wins_1_q, wins_1_d, wins_2_q, wins_2_d;
   logic [1:0]          countdown_q, countdown_d;
   winner_e             round_winner_q, round_winner_d;
   winner_e             match_winner_q, match_winner_d;
   logic                freeze_q, freeze_d;
   logic                round_reset_q, round_reset_d;
   logic                sync1_q, sync2_q, start_prev_q;

   logic                start_rise_c, enter_intro_c, clk_load_c, clk_en_c;
   logic                time_up_c, ko_c;
   winner_e             decide_c;

   assign start_rise_c = sync2_q & ~start_prev_q;
   assign ko_c         = (health_1 == '0) || (health_2 == '0);

   // KO rules first; otherwise the healthier player takes a time-up round.
   always_comb begin
      decide_c = WIN_DRAW;
      if ((health_1 == '0) && (health_2 == '0)) decide_c = WIN_DRAW;
      else if (health_2 == '0)                  decide_c = WIN_P1;
      else if (health_1 == '0)                  decide_c = WIN_P2;
      else if (health_1 > health_2)             decide_c = WIN_P1;
      else if (health_2 > health_1)             decide_c = WIN_P2;
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      round_no_d     = round_no_q;
      wins_1_d       = wins_1_q;
      wins_2_d       = wins_2_q;
      countdown_d    = countdown_q;
      round_winner_d = round_winner_q;
      match_winner_d = match_winner_q;
      round_reset_d  = round_reset_q && !tick;
      enter_intro_c  = 1'b0;
      clk_load_c     = 1'b0;
      clk_en_c       = 1'b0;

      case (state_q)
         ST_IDLE, ST_MATCH_OVER: begin
            if (start_rise_c) begin
               enter_intro_c  = 1'b1;
               wins_1_d       = '0;
               wins_2_d       = '0;
               round_no_d     = ROUND_W'(1);
               round_winner_d = WIN_NONE;
               match_winner_d = WIN_NONE;
            end
         end
         ST_INTRO: begin
            if (tick) begin
               if (cnt_q == INTRO_LAST) begin
                  state_d     = ST_FIGHT;
                  cnt_d       = '0;
                  countdown_d = 2'd0;
                  clk_load_c  = 1'b1;
               end else begin
                  cnt_d       = cnt_q + CNT_W'(1);
                  countdown_d = intro_digit(INTRO_TICKS - 32'(cnt_q) - 1, TICKS_PER_SEC);
               end
            end
         end
         ST_FIGHT: begin
            clk_en_c = tick;
            if (ko_c || time_up_c) begin
               state_d        = ST_KO;
               cnt_d          = '0;
               round_winner_d = decide_c;
               if (decide_c == WIN_P1 && wins_1_q != WINS_MAX) wins_1_d = wins_1_q + WINS_W'(1);
               if (decide_c == WIN_P2 && wins_2_q != WINS_MAX) wins_2_d = wins_2_q + WINS_W'(1);
            end
         end
         ST_KO: begin
            if (tick) begin
               if (cnt_q != KO_LAST) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end else if (wins_1_q == WINS_MAX) begin
                  state_d        = ST_MATCH_OVER;
                  match_winner_d = WIN_P1;
               end else if (wins_2_q == WINS_MAX) begin
                  state_d        = ST_MATCH_OVER;
                  match_winner_d = WIN_P2;
               end else if (round_no_q == ROUND_LAST) begin
                  state_d        = ST_MATCH_OVER;
                  match_winner_d = (wins_1_q > wins_2_q) ? WIN_P1 :
                                   (wins_2_q > wins_1_q) ? WIN_P2 : WIN_DRAW;
               end else begin
                  enter_intro_c  = 1'b1;
                  round_no_d     = round_no_q + ROUND_W'(1);
                  round_winner_d = WIN_NONE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Every INTRO entry restarts the countdown and raises round_reset.
      if (enter_intro_c) begin
         state_d       = ST_INTRO;
         cnt_d         = '0;
         countdown_d   = DIGIT_START;
         round_reset_d = 1'b1;
      end

      freeze_d = (state_d != ST_FIGHT);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         round_no_q     <= ROUND_W'(1);
         wins_1_q       <= '0;
         wins_2_q       <= '0;
         countdown_q    <= 2'd0;
         round_winner_q <= WIN_NONE;
         match_winner_q <= WIN_NONE;
         freeze_q       <= 1'b1;
         round_reset_q  <= 1'b0;
         sync1_q        <= 1'b0;
         sync2_q        <= 1'b0;
         start_prev_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         round_no_q     <= round_no_d;
         wins_1_q       <= wins_1_d;
         wins_2_q       <= wins_2_d;
         countdown_q    <= countdown_d;
         round_winner_q <= round_winner_d;
         match_winner_q <= match_winner_d;
         freeze_q       <= freeze_d;
         round_reset_q  <= round_reset_d;
         sync1_q        <= start_btn;
         sync2_q        <= sync1_q;
         start_prev_q   <= sync2_q;
      end
   end

   round_clock #(
      .TICKS_PER_SEC (TICKS_PER_SEC),
      .ROUND_TIME_S  (ROUND_TIME_S)
   ) u_round_clock (
      .clk         (clk),
      .rst_n       (reset),
      .load_i      (clk_load_c),
      .enable_i    (clk_en_c),
      .timer_sec_o (timer_sec),
      .time_up_o   (time_up_c)
   );

   assign state        = state_q;
   assign round_no     = round_no_q;
   assign wins_1       = wins_1_q;
   assign wins_2       = wins_2_q;
   assign countdown    = countdown_q;
   assign round_winner = round_winner_q;
   assign match_winner = match_winner_q;
   assign freeze       = freeze_q;
   assign round_reset  = round_reset_q;

endmodule

// File: tb/tb_round_manager.sv
// Directed bench for round_manager: decision table plus multi-round sequences.
module tb_round_manager;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       tick = 1'b0;
   logic [8:0] health_1 = 9'd100;
   logic [8:0] health_2 = 9'd100;
   logic       start_btn = 1'b0;
   logic       freeze, round_reset;
   logic [2:0] state, round_no;
   logic [1:0] wins_1, wins_2, countdown, round_winner, match_winner;
   logic [6:0] timer_sec;

   int n_cmp = 0;
   int n_err = 0;

   round_manager dut (
      .clk          (clk),
      .reset        (reset),
      .tick         (tick),
      .health_1     (health_1),
      .health_2     (health_2),
      .start_btn    (start_btn),
      .freeze       (freeze),
      .round_reset  (round_reset),
      .state        (state),
      .round_no     (round_no),
      .wins_1       (wins_1),
      .wins_2       (wins_2),
      .timer_sec    (timer_sec),
      .countdown    (countdown),
      .round_winner (round_winner),
      .match_winner (match_winner)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [8:0] h1;
      logic [8:0] h2;
      bit         timeup;
      int         exp_state;
      int         exp_rw;
      int         exp_w1;
      int         exp_w2;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One tick pulse every four clocks; returns on a falling edge.
   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk); tick = 1'b1;
         @(negedge clk); tick = 1'b0;
         @(negedge clk);
         @(negedge clk);
      end
   endtask

   task automatic press_start();
      @(negedge clk); start_btn = 1'b1;
      repeat (3) @(negedge clk);
      start_btn = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      @(negedge clk); reset = 1'b0;
      @(negedge clk); reset = 1'b1;
   endtask

   initial begin
      vecs[0] = '{h1: 9'd0,   h2: 9'd100, timeup: 1'b0, exp_state: 3, exp_rw: 2, exp_w1: 0, exp_w2: 1};
      vecs[1] = '{h1: 9'd100, h2: 9'd0,   timeup: 1'b0, exp_state: 3, exp_rw: 1, exp_w1: 1, exp_w2: 0};
      vecs[2] = '{h1: 9'd0,   h2: 9'd0,   timeup: 1'b0, exp_state: 3, exp_rw: 3, exp_w1: 0, exp_w2: 0};
      vecs[3] = '{h1: 9'd1,   h2: 9'd1,   timeup: 1'b0, exp_state: 2, exp_rw: 0, exp_w1: 0, exp_w2: 0};
      vecs[4] = '{h1: 9'd511, h2: 9'd1,   timeup: 1'b0, exp_state: 2, exp_rw: 0, exp_w1: 0, exp_w2: 0};
      vecs[5] = '{h1: 9'd80,  h2: 9'd120, timeup: 1'b1, exp_state: 3, exp_rw: 2, exp_w1: 0, exp_w2: 1};

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_state", 32'(state), 0);
      check("rst_freeze", 32'(freeze), 1);
      check("rst_round_reset", 32'(round_reset), 0);
      check("rst_round_no", 32'(round_no), 1);
      check("rst_wins", 32'({wins_1, wins_2}), 0);
      check("rst_timer", 32'(timer_sec), 60);
      check("rst_countdown", 32'(countdown), 0);
      check("rst_winners", 32'({round_winner, match_winner}), 0);
      reset = 1'b1;

      // Match start, round_reset window and intro countdown
      press_start();
      check("start_state", 32'(state), 1);
      check("start_rr", 32'(round_reset), 1);
      check("start_cd", 32'(countdown), 3);
      check("intro_freeze", 32'(freeze), 1);
      @(negedge clk); tick = 1'b1;
      check("rr_during_tick", 32'(round_reset), 1);
      @(negedge clk); tick = 1'b0;
      check("rr_after_tick", 32'(round_reset), 0);
      tick_n(18);
      check("cd_19", 32'(countdown), 3);
      tick_n(1);
      check("cd_20", 32'(countdown), 2);
      tick_n(20);
      check("cd_40", 32'(countdown), 1);
      tick_n(19);
      check("intro_59_state", 32'(state), 1);
      tick_n(1);
      check("fight_state", 32'(state), 2);
      check("fight_freeze", 32'(freeze), 0);
      check("fight_timer", 32'(timer_sec), 60);
      check("fight_cd", 32'(countdown), 0);
      tick_n(20);
      check("timer_after_1s", 32'(timer_sec), 59);

      // P1 KO, hold, next round
      @(negedge clk); health_2 = 9'd0;
      @(negedge clk); health_2 = 9'd100;
      check("ko1_state", 32'(state), 3);
      check("ko1_rw", 32'(round_winner), 1);
      check("ko1_w1", 32'(wins_1), 1);
      check("ko1_freeze", 32'(freeze), 1);
      tick_n(39);
      check("ko_hold_39", 32'(state), 3);
      tick_n(1);
      check("r2_state", 32'(state), 1);
      check("r2_round_no", 32'(round_no), 2);
      check("r2_rr", 32'(round_reset), 1);
      check("r2_rw", 32'(round_winner), 0);

      // Second P1 KO ends the match
      tick_n(60);
      @(negedge clk); health_2 = 9'd0;
      @(negedge clk); health_2 = 9'd100;
      check("ko2_w1", 32'(wins_1), 2);
      tick_n(40);
      check("mo_state", 32'(state), 4);
      check("mo_mw", 32'(match_winner), 1);
      check("mo_w1", 32'(wins_1), 2);
      check("mo_freeze", 32'(freeze), 1);
      press_start();
      check("restart_state", 32'(state), 1);
      check("restart_wins", 32'({wins_1, wins_2}), 0);
      check("restart_mw", 32'(match_winner), 0);
      check("restart_round", 32'(round_no), 1);

      // Time-up rounds: healthier player wins, then an equal-health draw
      tick_n(60);
      health_1 = 9'd120; health_2 = 9'd80;
      tick_n(1199);
      check("tu_timer_1", 32'(timer_sec), 1);
      check("tu_still_fight", 32'(state), 2);
      tick_n(1);
      check("tu_state", 32'(state), 3);
      check("tu_timer_0", 32'(timer_sec), 0);
      check("tu_rw", 32'(round_winner), 1);
      check("tu_w1", 32'(wins_1), 1);
      health_1 = 9'd100; health_2 = 9'd100;
      tick_n(40);
      tick_n(60);
      tick_n(1200);
      check("tu_eq_rw", 32'(round_winner), 3);
      check("tu_eq_wins", 32'({wins_1, wins_2}), 32'({2'd1, 2'd0}));
      tick_n(40);
      check("r3_round_no", 32'(round_no), 3);

      // Asynchronous reset mid-fight
      tick_n(60);
      tick_n(5);
      @(negedge clk); #2 reset = 1'b0;
      #1;
      check("mid_rst_state", 32'(state), 0);
      check("mid_rst_timer", 32'(timer_sec), 60);
      check("mid_rst_wins", 32'({wins_1, wins_2}), 0);
      check("mid_rst_rr", 32'(round_reset), 0);
      check("mid_rst_freeze", 32'(freeze), 1);
      @(negedge clk); reset = 1'b1;

      // Held start button across a full five-draw match
      @(negedge clk); start_btn = 1'b1;
      repeat (4) @(negedge clk);
      check("held_start_state", 32'(state), 1);
      for (int r = 1; r <= 5; r++) begin
         tick_n(60);
         @(negedge clk); health_1 = 9'd0; health_2 = 9'd0;
         @(negedge clk); health_1 = 9'd100; health_2 = 9'd100;
         check($sformatf("draw%0d_rw", r), 32'(round_winner), 3);
         check($sformatf("draw%0d_wins", r), 32'({wins_1, wins_2}), 0);
         tick_n(40);
         if (r < 5) check($sformatf("draw%0d_next_round", r), 32'(round_no), r + 1);
      end
      check("draws_state", 32'(state), 4);
      check("draws_mw", 32'(match_winner), 3);
      check("draws_round_no", 32'(round_no), 5);
      tick_n(10);
      check("held_no_restart", 32'(state), 4);
      start_btn = 1'b0;
      tick_n(2);
      check("release_no_restart", 32'(state), 4);

      // Decision table: each vector from a fresh match
      for (int v = 0; v < 6; v++) begin
         pulse_reset();
         press_start();
         tick_n(60);
         health_1 = vecs[v].h1; health_2 = vecs[v].h2;
         if (vecs[v].timeup) tick_n(1200);
         else repeat (2) @(negedge clk);
         check($sformatf("vec%0d_state", v), 32'(state), vecs[v].exp_state);
         check($sformatf("vec%0d_rw", v), 32'(round_winner), vecs[v].exp_rw);
         check($sformatf("vec%0d_w1", v), 32'(wins_1), vecs[v].exp_w1);
         check($sformatf("vec%0d_w2", v), 32'(wins_2), vecs[v].exp_w2);
         health_1 = 9'd100; health_2 = 9'd100;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
